sram_port_arb: RTL and testbench
================================

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning SRAM word width.
REQ-002 The block SHALL have parameter ADDR_W, default 9, meaning SRAM address width.
REQ-003 The block SHALL have parameter NUM_M, default 2, meaning number of parallel masters (range 1..8).
REQ-004 The block SHALL have these ports:
- CLK  in  1  Sole clock; all logic is on the rising edge.
- RST  in  1  Reset; synchronous, active-high.
- LOAD_MODE  in  1  Serial port owns the SRAM; masters are blocked.
- SI_VLD  in  1  SI bit valid this cycle.
- SI  in  1  Serial frame bit, MSB first.
- LD_WE  in  1  Frame type, sampled with the first SI bit: 1 = write, 0 = read.
- SO  out  1  Serial read data, MSB first.
- SO_VLD  out  1  SO valid.
- LD_RDY  out  1  One-cycle pulse when a serial frame completes.
- M_REQ  in  NUM_M  Master request.
- M_WE  in  NUM_M  Master write enable.
- M_ADDR  in  NUM_M*ADDR_W  Master addresses; master i uses slice i.
- M_WDATA  in  NUM_M*DATA_W  Master write data.
- M_GNT  out  NUM_M  One-hot grant.
- M_RVLD  out  NUM_M  Read data valid, per master.
- M_RDATA  out  DATA_W  Read data, shared by all masters.
- SRAM_CEN  out  1  SRAM chip enable, active low.
- SRAM_WEN  out  1  SRAM write enable, active low.
- SRAM_A  out  ADDR_W  SRAM address.
- SRAM_D  out  DATA_W  SRAM write data.
- SRAM_Q  in  DATA_W  SRAM read data; valid one cycle after a CEN=0, WEN=1 edge.

Function
REQ-005 Serial FSM states SHALL be IDLE, SHIFT_IN, ACCESS, WAIT_Q, SHIFT_OUT, DONE.
REQ-006 In IDLE with LOAD_MODE=1 and SI_VLD=1, the FSM SHALL latch LD_WE, capture the first bit and enter SHIFT_IN.
REQ-007 SHIFT_IN SHALL collect exactly ADDR_W+DATA_W bits (address first, then data) on SI_VLD cycles; cycles with SI_VLD=0 stall without loss.
REQ-008 On the last bit the FSM SHALL enter ACCESS and drive one SRAM cycle: SRAM_CEN=0, SRAM_WEN=!LD_WE, SRAM_A=shifted address, SRAM_D=shifted data. For a read frame, the data bits SHALL be shifted in but ignored.
REQ-009 After ACCESS, a write frame SHALL go to DONE; a read frame SHALL go to WAIT_Q, then load SRAM_Q into the shift register.
REQ-010 SHIFT_OUT SHALL drive SO/SO_VLD for exactly DATA_W consecutive cycles, MSB first, then enter DONE.
REQ-011 DONE SHALL pulse LD_RDY for one cycle and return to IDLE.
REQ-012 If LOAD_MODE falls in any state other than IDLE/DONE, the FSM SHALL abort to IDLE next cycle: no SRAM write, no LD_RDY, SO_VLD=0.
REQ-013 While LOAD_MODE=1 or the serial FSM is not IDLE, M_GNT SHALL be 0.
REQ-014 Otherwise, each cycle the arbiter SHALL grant one requesting master, round-robin starting after the last granted index; the first grant after reset searches from index 0.
REQ-015 A grant SHALL be combinational in the request cycle: M_GNT[i]=1, SRAM_CEN=0, SRAM_WEN=!M_WE[i], SRAM_A/SRAM_D taken from slice i.
REQ-016 A granted read SHALL assert M_RVLD[i] and M_RDATA=SRAM_Q exactly one cycle later.
REQ-017 Back-to-back grants SHALL be allowed every cycle; a master holding M_REQ with no competitor SHALL be granted every cycle.
REQ-018 With no grant and no serial access, SRAM_CEN SHALL be 1, SRAM_WEN SHALL be 1, and SRAM_A/SRAM_D SHALL be 0.
REQ-019 If LOAD_MODE rises in the same cycle as a master read grant, that grant SHALL still complete, with M_RVLD next cycle.
REQ-020 A serial frame SHALL NOT start until no master read is outstanding: IDLE waits one cycle if M_RVLD is pending.

Reset
REQ-021 While RST=1 at a clock edge: FSM→IDLE, bit counter=0, round-robin pointer=NUM_M-1 (so the next search starts at index 0), SO=0, SO_VLD=0, LD_RDY=0, M_RVLD=0, M_RDATA=0.
REQ-022 Reset mid-frame or mid-read SHALL discard all pending work; M_GNT and SRAM_CEN SHALL follow REQ-013/REQ-018 from the cycle after reset.

Verification
REQ-023 Serial write: defaults, LOAD_MODE=1, LD_WE=1, shift addr 0x0A5 then data 0x3C -> one cycle with SRAM_CEN=0, SRAM_WEN=0, A=0x0A5, D=0x3C, then one LD_RDY pulse.
REQ-024 Serial read: same address, LD_WE=0 -> SO emits 0,0,1,1,1,1,0,0 on 8 consecutive SO_VLD cycles, then LD_RDY.
REQ-025 Round-robin: NUM_M=2, both M_REQ held for 4 cycles -> M_GNT sequence 01,10,01,10 (bit0 = master 0).
REQ-026 Master 1 reads address 0x0A5 -> M_RVLD[1]=1 with M_RDATA=0x3C one cycle after M_GNT[1].
REQ-027 Abort: drop LOAD_MODE after 10 of 17 SI bits of a write frame -> no SRAM write, no LD_RDY, and masters granted the next cycle.
REQ-028 Reset: assert RST during SHIFT_OUT -> SO_VLD=0 next cycle, LD_RDY never pulses, and the first post-reset grant goes to master 0.

Source files
------------

// File: rtl/sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arb
// Purpose  : Shares one single-port synchronous SRAM between a bit-serial
//            load/readback port and NUM_M parallel masters. The serial port
//            owns the SRAM while LOAD_MODE is high or a frame is in flight.
//            Otherwise a round-robin arbiter grants one requesting master per
//            cycle.
// Ports    : CLK, RST         - clock, synchronous active-high reset
//            LOAD_MODE        - serial port ownership
//            SI_VLD/SI/LD_WE  - serial frame input (address then data, MSB first)
//            SO/SO_VLD/LD_RDY - serial read data and frame-complete pulse
//            M_REQ/M_WE/M_ADDR/M_WDATA - master requests (slice i = master i)
//            M_GNT/M_RVLD/M_RDATA      - one-hot grant, read return
//            SRAM_CEN/WEN/A/D/Q        - SRAM macro interface (active-low enables)
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int NUM_M  = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     LOAD_MODE,
  input  logic                     SI_VLD,
  input  logic                     SI,
  input  logic                     LD_WE,
  output logic                     SO,
  output logic                     SO_VLD,
  output logic                     LD_RDY,
  input  logic [NUM_M-1:0]         M_REQ,
  input  logic [NUM_M-1:0]         M_WE,
  input  logic [NUM_M*ADDR_W-1:0]  M_ADDR,
  input  logic [NUM_M*DATA_W-1:0]  M_WDATA,
  output logic [NUM_M-1:0]         M_GNT,
  output logic [NUM_M-1:0]         M_RVLD,
  output logic [DATA_W-1:0]        M_RDATA,
  output logic                     SRAM_CEN,
  output logic                     SRAM_WEN,
  output logic [ADDR_W-1:0]        SRAM_A,
  output logic [DATA_W-1:0]        SRAM_D,
  input  logic [DATA_W-1:0]        SRAM_Q
);

  localparam int c_frame_w = ADDR_W + DATA_W;
  localparam int c_cnt_w   = $clog2(c_frame_w + 1);
  localparam int c_ptr_w   = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [c_cnt_w-1:0] c_in_last  = c_cnt_w'(c_frame_w - 1);
  localparam logic [c_cnt_w-1:0] c_out_last = c_cnt_w'(DATA_W);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_rst  = c_ptr_w'(NUM_M - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_ACCESS    = 3'd2,
    S_WAIT_Q    = 3'd3,
    S_SHIFT_OUT = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_frame_w-1:0]  r_shreg;
  logic                  r_ld_we;
  logic                  r_so;
  logic                  r_so_vld;
  logic                  r_ld_rdy;
  logic [c_ptr_w-1:0]    r_ptr;
  logic [NUM_M-1:0]      r_m_rvld;

  logic                  w_arb_en;
  logic                  w_found;
  logic [c_ptr_w-1:0]    w_gnt_idx;
  logic [NUM_M-1:0]      w_gnt;
  logic                  w_ser_acc;
  logic                  w_abort;

  // Serial FSM. Abort takes priority in every in-flight state.
  assign w_abort = !LOAD_MODE && (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_ld_we  <= 1'b0;
      r_so     <= 1'b0;
      r_so_vld <= 1'b0;
      r_ld_rdy <= 1'b0;
    end else if (w_abort) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_so     <= 1'b0;
      r_so_vld <= 1'b0;
      r_ld_rdy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A master read returning this cycle still owns SRAM_Q; hold off.
          if (LOAD_MODE && SI_VLD && !(|r_m_rvld)) begin
            r_ld_we <= LD_WE;
            r_shreg <= {r_shreg[c_frame_w-2:0], SI};
            r_cnt   <= c_cnt_one;
            r_state <= S_SHIFT_IN;
          end
        end
        S_SHIFT_IN: begin
          if (SI_VLD) begin
            r_shreg <= {r_shreg[c_frame_w-2:0], SI};
            if (r_cnt == c_in_last) begin
              r_cnt   <= '0;
              r_state <= S_ACCESS;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
        end
        S_ACCESS: begin
          if (r_ld_we) begin
            r_ld_rdy <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_WAIT_Q;
          end
        end
        S_WAIT_Q: begin
          // First bit goes straight to SO; the rest wait in the data field.
          r_so                  <= SRAM_Q[DATA_W-1];
          r_so_vld              <= 1'b1;
          r_shreg[DATA_W-1:0]   <= {SRAM_Q[DATA_W-2:0], 1'b0};
          r_cnt                 <= c_cnt_one;
          r_state               <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          if (r_cnt == c_out_last) begin
            r_so     <= 1'b0;
            r_so_vld <= 1'b0;
            r_ld_rdy <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end else begin
            r_so                <= r_shreg[DATA_W-1];
            r_shreg[DATA_W-1:0] <= {r_shreg[DATA_W-2:0], 1'b0};
            r_cnt               <= r_cnt + c_cnt_one;
          end
        end
        S_DONE: begin
          r_ld_rdy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Round-robin search: first indices above the last grant, then wrap to 0.
  assign w_arb_en = !LOAD_MODE && (r_state == S_IDLE);

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    if (w_arb_en) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (!w_found && M_REQ[i] && (i > int'(r_ptr))) begin
          w_found   = 1'b1;
          w_gnt_idx = c_ptr_w'(i);
        end
      end
      for (int i = 0; i < NUM_M; i++) begin
        if (!w_found && M_REQ[i]) begin
          w_found   = 1'b1;
          w_gnt_idx = c_ptr_w'(i);
        end
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (w_found && (w_gnt_idx == c_ptr_w'(i))) begin
        w_gnt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr    <= c_ptr_rst;
      r_m_rvld <= '0;
    end else begin
      if (w_found) begin
        r_ptr <= w_gnt_idx;
      end
      r_m_rvld <= w_gnt & ~M_WE;
    end
  end

  // Serial access is gated by LOAD_MODE so an abort in ACCESS writes nothing.
  assign w_ser_acc = (r_state == S_ACCESS) && LOAD_MODE;

  always_comb begin
    SRAM_CEN = 1'b1;
    SRAM_WEN = 1'b1;
    SRAM_A   = '0;
    SRAM_D   = '0;
    if (w_ser_acc) begin
      SRAM_CEN = 1'b0;
      SRAM_WEN = !r_ld_we;
      SRAM_A   = r_shreg[c_frame_w-1 -: ADDR_W];
      SRAM_D   = r_shreg[DATA_W-1:0];
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (w_gnt[i]) begin
          SRAM_CEN = 1'b0;
          SRAM_WEN = !M_WE[i];
          SRAM_A   = M_ADDR[i*ADDR_W +: ADDR_W];
          SRAM_D   = M_WDATA[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign M_GNT   = w_gnt;
  assign M_RVLD  = r_m_rvld;
  // SRAM_Q is only meaningful in the cycle after a read grant.
  assign M_RDATA = (|r_m_rvld) ? SRAM_Q : '0;
  assign SO      = r_so;
  assign SO_VLD  = r_so_vld;
  assign LD_RDY  = r_ld_rdy;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arb
// Purpose  : Directed bench for sram_port_arb with a behavioural SRAM and a
//            queue-based scoreboard checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        LOAD_MODE, SI_VLD, SI, LD_WE;
  logic        SO, SO_VLD, LD_RDY;
  logic [1:0]  M_REQ, M_WE, M_GNT, M_RVLD;
  logic [17:0] M_ADDR;
  logic [15:0] M_WDATA;
  logic [7:0]  M_RDATA;
  logic        SRAM_CEN, SRAM_WEN;
  logic [8:0]  SRAM_A;
  logic [7:0]  SRAM_D;
  logic [7:0]  SRAM_Q = 8'h00;

  logic [7:0]  mem [0:511];

  logic [19:0] q_sram [$];   // {gnt, wen, addr, data}
  logic        q_so   [$];
  logic [9:0]  q_rvld [$];   // {rvld, rdata}
  logic        q_rdy  [$];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        mon_en   = 1'b0;

  always #5 CLK = ~CLK;

  sram_port_arb #(.DATA_W(8), .ADDR_W(9), .NUM_M(2)) dut (
    .CLK(CLK), .RST(RST), .LOAD_MODE(LOAD_MODE), .SI_VLD(SI_VLD), .SI(SI),
    .LD_WE(LD_WE), .SO(SO), .SO_VLD(SO_VLD), .LD_RDY(LD_RDY),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_GNT(M_GNT), .M_RVLD(M_RVLD), .M_RDATA(M_RDATA),
    .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A),
    .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  // Synchronous SRAM: read data appears after the accessing edge.
  always @(posedge CLK) begin
    if (!SRAM_CEN) begin
      if (!SRAM_WEN) mem[SRAM_A] <= SRAM_D;
      else           SRAM_Q      <= mem[SRAM_A];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: unexpected output %h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (!SRAM_CEN) begin
        if (q_sram.size() == 0) unexpected("sram_access", {M_GNT, SRAM_WEN, SRAM_A, SRAM_D});
        else check("sram_access", {M_GNT, SRAM_WEN, SRAM_A, SRAM_D}, q_sram.pop_front());
      end else begin
        check("sram_idle", {M_GNT, SRAM_WEN, SRAM_A, SRAM_D}, {2'b00, 1'b1, 9'h000, 8'h00});
      end
      if (SO_VLD) begin
        if (q_so.size() == 0) unexpected("so_bit", SO);
        else check("so_bit", SO, q_so.pop_front());
      end
      if (LD_RDY) begin
        if (q_rdy.size() == 0) unexpected("ld_rdy", LD_RDY);
        else check("ld_rdy", LD_RDY, q_rdy.pop_front());
      end
      if (|M_RVLD) begin
        if (q_rvld.size() == 0) unexpected("m_rvld", {M_RVLD, M_RDATA});
        else check("m_rvld", {M_RVLD, M_RDATA}, q_rvld.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_serial_write(input logic [8:0] a, input logic [7:0] d);
    q_sram.push_back({2'b00, 1'b0, a, d});
    q_rdy.push_back(1'b1);
  endtask

  task automatic exp_serial_read(input logic [8:0] a, input logic [7:0] q, input int nbits, input logic rdy);
    q_sram.push_back({2'b00, 1'b1, a, 8'h00});
    for (int k = 7; k > 7 - nbits; k--) q_so.push_back(q[k]);
    if (rdy) q_rdy.push_back(1'b1);
  endtask

  // Sends a 17-bit frame; stall_at inserts one SI_VLD=0 cycle after that many bits.
  task automatic send_frame(input logic we, input logic [8:0] a, input logic [7:0] d, input int stall_at);
    logic [16:0] f;
    f = {a, d};
    LD_WE = we;
    LOAD_MODE = 1'b1;
    for (int k = 16; k >= 0; k--) begin
      if (16 - k == stall_at) begin
        SI_VLD = 1'b0;
        SI = ~f[k];
        tick();
      end
      SI_VLD = 1'b1;
      SI = f[k];
      tick();
    end
    SI_VLD = 1'b0;
    SI = 1'b0;
  endtask

  initial begin
    RST = 1'b1; LOAD_MODE = 1'b0; SI_VLD = 1'b0; SI = 1'b0; LD_WE = 1'b0;
    M_REQ = 2'b00; M_WE = 2'b00; M_ADDR = '0; M_WDATA = '0;
    repeat (3) tick();

    // Reset state
    check("rst_so",      SO, 1'b0);
    check("rst_so_vld",  SO_VLD, 1'b0);
    check("rst_ld_rdy",  LD_RDY, 1'b0);
    check("rst_m_rvld",  M_RVLD, 2'b00);
    check("rst_m_rdata", M_RDATA, 8'h00);
    check("rst_cen",     SRAM_CEN, 1'b1);
    RST = 1'b0;
    mon_en = 1'b1;
    tick();

    // Round-robin with both masters writing: 01,10,01,10
    M_WE = 2'b11;
    M_ADDR = {9'h020, 9'h010};
    M_WDATA = {8'h22, 8'h11};
    M_REQ = 2'b11;
    q_sram.push_back({2'b01, 1'b0, 9'h010, 8'h11});
    q_sram.push_back({2'b10, 1'b0, 9'h020, 8'h22});
    q_sram.push_back({2'b01, 1'b0, 9'h010, 8'h11});
    q_sram.push_back({2'b10, 1'b0, 9'h020, 8'h22});
    repeat (4) tick();
    M_REQ = 2'b00;
    tick();

    // Serial write 0x0A5 <- 0x3C with one stall cycle mid-frame
    exp_serial_write(9'h0A5, 8'h3C);
    send_frame(1'b1, 9'h0A5, 8'h3C, 5);
    repeat (3) tick();
    LOAD_MODE = 1'b0;
    tick();

    // Serial read 0x0A5 -> 0,0,1,1,1,1,0,0
    exp_serial_read(9'h0A5, 8'h3C, 8, 1'b1);
    send_frame(1'b0, 9'h0A5, 8'h00, -1);
    repeat (12) tick();
    LOAD_MODE = 1'b0;
    tick();

    // Master 1 reads 0x0A5; read data one cycle after the grant
    M_WE = 2'b00;
    M_ADDR = {9'h0A5, 9'h000};
    M_WDATA = {8'h55, 8'h00};
    M_REQ = 2'b10;
    q_sram.push_back({2'b10, 1'b1, 9'h0A5, 8'h55});
    q_rvld.push_back({2'b10, 8'h3C});
    tick();
    M_REQ = 2'b00;
    tick();

    // Master 0 read, LOAD_MODE rises with the read still returning:
    // the first SI bit is offered during the pending cycle and must be ignored.
    M_ADDR = {9'h000, 9'h010};
    M_WDATA = 16'h0000;
    M_REQ = 2'b01;
    q_sram.push_back({2'b01, 1'b1, 9'h010, 8'h00});
    q_rvld.push_back({2'b01, 8'h11});
    exp_serial_read(9'h020, 8'h22, 8, 1'b1);
    tick();
    M_REQ = 2'b00;
    LOAD_MODE = 1'b1; LD_WE = 1'b0; SI_VLD = 1'b1; SI = 1'b0;
    tick();
    send_frame(1'b0, 9'h020, 8'h00, -1);
    repeat (12) tick();
    LOAD_MODE = 1'b0;
    tick();

    // Abort after 10 of 17 bits of a write frame; master 1 granted next cycle
    begin
      logic [16:0] f;
      f = {9'h0A5, 8'hFF};
      LD_WE = 1'b1;
      LOAD_MODE = 1'b1;
      for (int k = 16; k >= 7; k--) begin
        SI_VLD = 1'b1;
        SI = f[k];
        tick();
      end
    end
    LOAD_MODE = 1'b0; SI_VLD = 1'b0; SI = 1'b0;
    tick();
    M_WE = 2'b10;
    M_ADDR = {9'h0A5, 9'h000};
    M_WDATA = {8'h77, 8'h00};
    M_REQ = 2'b10;
    q_sram.push_back({2'b10, 1'b0, 9'h0A5, 8'h77});
    tick();
    M_REQ = 2'b00;
    tick();
    M_WE = 2'b00;
    M_WDATA = 16'h0000;
    M_REQ = 2'b10;
    q_sram.push_back({2'b10, 1'b1, 9'h0A5, 8'h00});
    q_rvld.push_back({2'b10, 8'h77});
    tick();
    M_REQ = 2'b00;
    tick();

    // Reset during SHIFT_OUT of a read of 0x020 after three SO bits
    exp_serial_read(9'h020, 8'h22, 3, 1'b0);
    send_frame(1'b0, 9'h020, 8'h00, -1);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    LOAD_MODE = 1'b0;
    check("post_rst_so_vld", SO_VLD, 1'b0);
    check("post_rst_ld_rdy", LD_RDY, 1'b0);
    M_WE = 2'b11;
    M_ADDR = {9'h040, 9'h030};
    M_WDATA = {8'h44, 8'h33};
    M_REQ = 2'b11;
    q_sram.push_back({2'b01, 1'b0, 9'h030, 8'h33});
    tick();
    M_REQ = 2'b00;

    repeat (20) tick();
    check("left_sram", q_sram.size(), 0);
    check("left_so",   q_so.size(), 0);
    check("left_rvld", q_rvld.size(), 0);
    check("left_rdy",  q_rdy.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
